// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared types for the unified memory arbiter
// Holds the arbiter state encoding and the grant selector type.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/unified_mem_arbiter_timeout_counter.sv
// rtl/unified_mem_arbiter_timeout_counter.sv - busy-cycle watchdog for the arbiter
// Ports:
//   clk     in  clock, rising edge
//   rst     in  asynchronous active-low reset
//   en      in  arbiter is in a BUSY state this cycle
//   clr     in  restart the count
//   expired out high during the TIMEOUT-th consecutive busy cycle
// TIMEOUT = 0 disables the watchdog (expired tied low).
module arb_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] cnt;

      // cnt holds the number of busy cycles already completed, so the
      // TIMEOUT-th busy cycle is the one where cnt == TIMEOUT-1.
      assign expired = en && (cnt == CW'(TIMEOUT - 1));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en && !expired) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port memory between fetch and data ports
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr                fetch request, held until if_ready
//   if_rdata/if_ready             registered instruction, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata data request, held until dm_ready
//   dm_rdata/dm_ready             registered load data, one-cycle completion pulse
//   if_stall/dm_stall             combinational stall requests to the hazard unit
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack             memory read data and single-cycle completion
//   err                           watchdog abort pulse, coincident with *_ready
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_ready,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             dm_ready,
  output logic             if_stall,
  output logic             dm_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             err
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);

  arb_state_t    state;
  arb_grant_t    grant;
  logic [SW-1:0] dm_streak;
  logic          streak_full;
  logic          busy;
  logic          expired;

  assign busy        = (state == IF_BUSY) || (state == DM_BUSY);
  assign streak_full = (dm_streak == SW'(MAX_DM_STREAK));
  // Data wins unless a waiting fetch has already been passed over too often.
  assign grant       = (dm_req && !(if_req && streak_full)) ? GRANT_DM : GRANT_IF;

  assign if_stall = if_req & ~if_ready;
  assign dm_stall = dm_req & ~dm_ready;

  arb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (busy),
    .clr    (state == IDLE),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dm_streak <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            mem_req <= 1'b1;
            if (grant == GRANT_DM) begin
              state     <= DM_BUSY;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              // Only grants that bypass a waiting fetch count toward the streak.
              if (if_req) begin
                dm_streak <= streak_full ? dm_streak : dm_streak + SW'(1);
              end else begin
                dm_streak <= '0;
              end
            end else begin
              state     <= IF_BUSY;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              dm_streak <= '0;
            end
          end
        end
        IF_BUSY, DM_BUSY: begin
          // An ack arriving in the expiry cycle wins over the abort.
          if (mem_ack || expired) begin
            state   <= DONE;
            mem_req <= 1'b0;
            err     <= ~mem_ack;
            if (state == IF_BUSY) begin
              if_ready <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              dm_ready <= 1'b1;
              if (!mem_ack) begin
                dm_rdata <= '0;
              end else if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
          end
        end
        DONE: begin
          // No arbitration here: the requester gets a cycle to advance its address.
          state    <= IDLE;
          if_ready <= 1'b0;
          dm_ready <= 1'b0;
          err      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbiter and sequencer that shares one single-port unified memory between the pipeline's instruction-fetch port (`pc_f` → `instr_f`) and memory-stage data port (`mem_addr_m`/`mem_data_m` → `read_data_m`). It handles the memory's variable-latency request/acknowledge handshake. Data accesses have priority, with a bounded fetch-starvation limit. Per-port stall requests go to the hazard unit, which derives `stall_f`/`stall_d`/`flush_*` from them.

## Interface
Parameters:
- `WIDTH`, 32, address and data width.
- `MAX_DM_STREAK`, 4, maximum consecutive data grants while a fetch is pending (≥1).
- `TIMEOUT`, 64, cycles in a busy state without `mem_ack` before abort; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_ready`.
- `if_addr`  in  WIDTH  fetch address (`pc_f`).
- `if_rdata`  out  WIDTH  registered fetched instruction.
- `if_ready`  out  1  one-cycle fetch completion pulse.
- `dm_req`  in  1  data request; held until `dm_ready`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  WIDTH  data address.
- `dm_wdata`  in  WIDTH  store data.
- `dm_rdata`  out  WIDTH  registered load data.
- `dm_ready`  out  1  one-cycle data completion pulse.
- `if_stall`  out  1  `if_req & ~if_ready`, combinational.
- `dm_stall`  out  1  `dm_req & ~dm_ready`, combinational.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  memory write enable, registered.
- `mem_addr`  out  WIDTH  memory address, registered.
- `mem_wdata`  out  WIDTH  memory write data, registered.
- `mem_rdata`  in  WIDTH  memory read data, valid with `mem_ack`.
- `mem_ack`  in  1  single-cycle completion; legal in any cycle `mem_req`=1, including the first.
- `err`  out  1  one-cycle pulse, coincident with `*_ready`, on watchdog abort.

## Operation
- State machine states and transitions:
  - IDLE → IF_BUSY or DM_BUSY on grant; stays in IDLE when there is no request.
  - IF_BUSY/DM_BUSY → DONE on `mem_ack` or on timeout.
  - DONE → IDLE unconditionally.
- Arbitration happens only in IDLE:
  - `dm_req` wins, unless `if_req`=1 and `dm_streak`==`MAX_DM_STREAK`; then fetch wins.
  - `dm_streak` increments on each data grant made while `if_req`=1.
  - `dm_streak` clears on any fetch grant, and on any data grant made with `if_req`=0.
  - `dm_streak` saturates at `MAX_DM_STREAK`.
- Grant behaviour:
  - On grant, `mem_addr`/`mem_we`/`mem_wdata` are loaded from the winner (fetch: `mem_we`=0, `mem_wdata`=0).
  - `mem_req`=1 from the next cycle until the ack/timeout cycle inclusive.
  - Address and data outputs stay stable while `mem_req`=1.
- Completion:
  - On `mem_ack` in IF_BUSY: `if_rdata`←`mem_rdata`.
  - On `mem_ack` in DM_BUSY with `mem_we`=0: `dm_rdata`←`mem_rdata`. Stores leave `dm_rdata` unchanged.
  - The matching `*_ready` is 1 in DONE.
- Timeout:
  - The busy-cycle counter counts cycles spent in a BUSY state.
  - When it reaches `TIMEOUT` without an ack: `mem_req` drops at the next edge and the machine enters DONE.
  - In DONE after a timeout: `*_ready`=1, `err`=1, the read-data register loads 0.
- No arbitration in DONE. This guarantees the requester updates its address (e.g. the PC) before the next sample.
- Boundary conditions:
  - `mem_ack` in IDLE or DONE is ignored.
  - A request dropped after grant still completes, and `*_ready` still pulses.
  - Ack and timeout in the same cycle: the ack wins and `err`=0.
  - `rst` low mid-access aborts immediately; the memory must tolerate `mem_req` falling without an ack.

## Timing
- Reset values: all outputs 0, state IDLE, `dm_streak`=0, busy-cycle counter 0.
- Minimum access timeline (grant in IDLE at cycle t, `mem_ack` at t+1):
  - t: grant.
  - t+1: `mem_req` high, ack arrives.
  - t+2: DONE, `*_ready` high.
  - t+3: IDLE, next grant possible.
  - Throughput: 3 cycles per access.
- Ack at cycle t+k: `*_ready` at t+k+1.
- `if_stall`/`dm_stall` are combinational from inputs and the registered `*_ready`. They add no latency.

## Structure
- Shared `types` package holds:
  - `arb_state_t` (IDLE, IF_BUSY, DM_BUSY, DONE).
  - `arb_grant_t` (GRANT_IF, GRANT_DM).
- One sub-module, `arb_timeout_counter`:
  - Parameter: `TIMEOUT`.
  - Inputs: `clk`, `rst`, `en` (state is a BUSY state), `clr`.
  - Output: `expired`.
  - Constant 0 output when `TIMEOUT`=0.
- Remaining logic (FSM, streak counter, output registers) lives in `unified_mem_arbiter`.

## Test plan
- Reset mid-access: `rst` low during DM_BUSY → `mem_req`, `*_ready`, `err` all 0 asynchronously; state IDLE after `rst` released.
- Single fetch: `if_req`=1, `if_addr`=0x100, `mem_ack` with `mem_rdata`=0x00500093 one cycle after `mem_req` rises → `mem_addr`=0x100, `mem_we`=0; `if_ready` pulse with `if_rdata`=0x00500093 at t+2; `if_stall` high t..t+1.
- Simultaneous requests: `if_req`=`dm_req`=1, `dm_we`=1, `dm_addr`=0x2000, `dm_wdata`=0xCAFE → data granted first, `mem_we`=1; after `dm_ready`, fetch is granted at the next IDLE.
- Starvation: `dm_req` held high for 10 accesses with `if_req`=1, `MAX_DM_STREAK`=4 → grant order D,D,D,D,F,D,D,D,D,F.
- Timeout: `TIMEOUT`=8, `dm_we`=0, no `mem_ack` → `mem_req` high exactly 8 cycles; `dm_ready`=`err`=1 in DONE; `dm_rdata`=0.
- Spurious ack and latency: `mem_ack` in IDLE → ignored. Ack latency 5 → `*_ready` exactly 1 cycle after ack. Ack in the same cycle as timeout expiry → `err`=0.
